iterative_divider_exc: RTL and testbench
========================================

Name: iterative_divider_exc

Overview:
Multi-cycle radix-2 restoring divider for the multiply-division unit. It supports signed and unsigned modes. Integrated exception detection (signed overflow, divide-by-zero) takes a 1-cycle fast path with architecturally defined results. It generalises the combinational overflow check into a parametrised, handshaked, sequential datapath.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted when start && ready
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
dividend  in  WIDTH  dividend, sampled at accept
divisor  in  WIDTH  divisor, sampled at accept
ready  out  1  high only in IDLE
out_ready  in  1  consumer accepts result when valid_out && out_ready
valid_out  out  1  result valid; held until consumed
quotient  out  WIDTH  quotient
remainder  out  WIDTH  remainder (sign follows dividend in signed mode)
overflow  out  1  signed MIN / -1 detected; valid with valid_out
div_by_zero  out  1  divisor == 0; valid with valid_out

Behaviour:
- Reset (async, rst_n=0): state=IDLE, ready=1, valid_out=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, counter=0. Reset mid-operation abandons the op with no output.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: on accept, latch operands and mode, and evaluate exceptions on the raw inputs.
  - divisor==0 -> DONE next cycle. div_by_zero=1, quotient=all ones, remainder=dividend. Applies in both modes.
  - else is_signed && dividend==1<<(WIDTH-1) && divisor==all ones -> DONE next cycle. overflow=1, quotient=dividend, remainder=0.
  - else -> PREP.
  - Divide-by-zero takes priority; the two flags are never both set.
- PREP (1 cycle): in signed mode, take absolute values and record q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend). Clear partial remainder (WIDTH+1 bits) and set counter=WIDTH.
- ITER (WIDTH cycles): shift {rem,quo} left by 1 and trial-subtract |divisor|. If non-negative, keep the result and set the quotient LSB to 1; else restore. Decrement counter. Go to FIX when counter reaches 1 on that cycle.
- FIX (1 cycle): negate quotient if q_neg and remainder if r_neg, then register outputs -> DONE.
- DONE: valid_out=1 with outputs stable. When out_ready=1, go to IDLE next cycle with valid_out=0 and flags cleared; data outputs keep their last value.
- Latency, counted as edges from the accept edge to valid_out high: normal = WIDTH+3 (35 at default), exception = 1.
- start is ignored while not IDLE. Back-to-back issue is possible: the earliest next accept is the cycle after the result is consumed.
- Absolute value of MIN in signed mode uses the WIDTH+1-bit datapath, so there is no wrap. Example: MIN / 2 = -(2^(WIDTH-2)) correctly.
- Unsigned mode never raises overflow.

Optional Feature:
Macro DIV_STICKY_FLAGS_EN.
- Defined: adds ports flag_clr (in, 1), sticky_ovf (out, 1) and sticky_dz (out, 1).
  - Sticky bits set in the cycle a result with the matching flag is consumed (valid_out && out_ready).
  - flag_clr=1 clears them on the next edge; a simultaneous set wins over clear.
  - Both reset to 0.
- Undefined: ports absent and no extra state; per-result flags are unchanged.

Decomposition:
- Package div_pkg:
  - typedef enum logic [2:0] div_state_t {IDLE, PREP, ITER, FIX, DONE}
  - function is_min_neg(value, width)
  - localparam constants for exception quotient patterns
- One sub-module: div_exc_detect. It is a combinational WIDTH-parametrised detector (divisor, dividend, is_signed -> overflow, div_by_zero) and is instantiated in IDLE decode.

Test Plan:
- Signed 0x80000000 / 0xFFFFFFFF -> valid_out 1 cycle after accept; overflow=1, div_by_zero=0, quotient=0x80000000, remainder=0.
- Unsigned 100 / 0 and signed -5 / 0 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=100 and 0xFFFFFFFB respectively; latency 1.
- Signed -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, flags 0, valid_out exactly 35 edges after accept.
- Unsigned 0xFFFFFFFF / 0xFFFFFFFF -> quotient=1, remainder=0, overflow=0. Then unsigned 0x80000000 / 0xFFFFFFFF -> quotient=0, remainder=0x80000000, overflow=0.
- Backpressure and mid-op: out_ready=0 for 5 cycles -> valid_out and outputs stable, and start pulses are ignored with ready=0. Separately, assert rst_n=0 in cycle 10 of ITER -> immediate IDLE with all outputs 0. A new 1000 / 7 then yields quotient 142, remainder 6.
- Sticky flags (with macro): consume one overflow result -> sticky_ovf=1 persists. Pulse flag_clr -> 0 next edge. flag_clr together with a consumed div-by-zero result -> sticky_dz=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} div_state_t;

  localparam int MAX_WIDTH = 64;

  // Architectural exception results; callers take the low WIDTH bits.
  localparam logic [MAX_WIDTH-1:0] DZ_QUOTIENT   = '1;
  localparam logic [MAX_WIDTH-1:0] OVF_REMAINDER = '0;

  // True when the low 'width' bits of value hold the most negative number.
  function automatic logic is_min_neg(input logic [MAX_WIDTH-1:0] value, input int width);
    logic [MAX_WIDTH-1:0] min_neg;
    min_neg = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    return value == min_neg;
  endfunction

endpackage

// File: rtl/iterative_divider_exc_if.sv
// Request/response bus of the iterative divider.
interface iterative_divider_exc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             out_ready;
    logic             valid_out;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, out_ready,
        input  ready, valid_out, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, out_ready,
        output ready, valid_out, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/div_exc_detect.sv
// Combinational exception detector evaluated on raw operands at accept.
module div_exc_detect
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             overflow,
    output logic             div_by_zero
);
    assign div_by_zero = (divisor == '0);

    // Divide-by-zero has priority, so the two flags are mutually exclusive.
    assign overflow = !div_by_zero && is_signed && (divisor == '1)
                      && is_min_neg(MAX_WIDTH'(dividend), WIDTH);
endmodule

// File: rtl/iterative_divider_exc.sv
// Radix-2 restoring divider, signed/unsigned, with a one-cycle exception path.
// Optional sticky exception flags are built when DIV_STICKY_FLAGS_EN is defined.
module iterative_divider_exc
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    iterative_divider_exc_if.slave  bus
`ifdef DIV_STICKY_FLAGS_EN
    ,
    input  logic                    flag_clr,
    output logic                    sticky_ovf,
    output logic                    sticky_dz
`endif
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state, next_state;
    logic [WIDTH-1:0] opa, opb;
    logic             op_signed;
    logic             q_neg, r_neg;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   dvs;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quotient_r, remainder_r;
    logic             ovf_r, dz_r;

    logic             exc_ovf, exc_dz;
    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH:0]   diff;
    logic             trial_ok;

    div_exc_detect #(.WIDTH(WIDTH)) u_exc (
        .dividend    (bus.dividend),
        .divisor     (bus.divisor),
        .is_signed   (bus.is_signed),
        .overflow    (exc_ovf),
        .div_by_zero (exc_dz)
    );

    assign accept = bus.start && (state == IDLE);

    // |MIN| of the dividend is 2^(WIDTH-1), which is exact as a WIDTH-bit unsigned value.
    assign a_neg  = op_signed && opa[WIDTH-1];
    assign b_neg  = op_signed && opb[WIDTH-1];
    assign abs_a  = a_neg ? (~opa + 1'b1) : opa;
    assign abs_b  = b_neg ? (~{1'b1, opb} + 1'b1) : {1'b0, opb};

    assign rem_sh   = {rem, quo[WIDTH-1]};
    assign trial_ok = (rem_sh >= {1'b0, dvs});
    assign diff     = rem_sh[WIDTH:0] - dvs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept) next_state = (exc_dz || exc_ovf) ? DONE : PREP;
            PREP: next_state = ITER;
            ITER: if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa         <= '0;
            opb         <= '0;
            op_signed   <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    opa       <= bus.dividend;
                    opb       <= bus.divisor;
                    op_signed <= bus.is_signed;
                    if (exc_dz) begin
                        quotient_r  <= DZ_QUOTIENT[WIDTH-1:0];
                        remainder_r <= bus.dividend;
                        dz_r        <= 1'b1;
                        ovf_r       <= 1'b0;
                    end else if (exc_ovf) begin
                        quotient_r  <= bus.dividend;
                        remainder_r <= OVF_REMAINDER[WIDTH-1:0];
                        ovf_r       <= 1'b1;
                        dz_r        <= 1'b0;
                    end
                end
                PREP: begin
                    quo   <= abs_a;
                    dvs   <= abs_b;
                    rem   <= '0;
                    cnt   <= CNT_W'(WIDTH);
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                end
                ITER: begin
                    rem <= trial_ok ? diff : rem_sh[WIDTH:0];
                    quo <= {quo[WIDTH-2:0], trial_ok};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    quotient_r  <= q_neg ? (~quo + 1'b1) : quo;
                    remainder_r <= r_neg ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
                    ovf_r       <= 1'b0;
                    dz_r        <= 1'b0;
                end
                DONE: if (bus.out_ready) begin
                    ovf_r <= 1'b0;
                    dz_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.valid_out   = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.overflow    = ovf_r;
    assign bus.div_by_zero = dz_r;

`ifdef DIV_STICKY_FLAGS_EN
    logic consume;
    assign consume = bus.valid_out && bus.out_ready;

    // Setting takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_dz  <= 1'b0;
        end else begin
            if (consume && ovf_r)  sticky_ovf <= 1'b1;
            else if (flag_clr)     sticky_ovf <= 1'b0;
            if (consume && dz_r)   sticky_dz  <= 1'b1;
            else if (flag_clr)     sticky_dz  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_iterative_divider_exc.sv
// Scoreboard bench for iterative_divider_exc; sticky checks under DIV_STICKY_FLAGS_EN.
module tb_iterative_divider_exc;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dz;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    iterative_divider_exc_if #(.WIDTH(W)) bus();

`ifdef DIV_STICKY_FLAGS_EN
    logic flag_clr = 1'b0;
    logic sticky_ovf, sticky_dz;
`endif

    iterative_divider_exc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DIV_STICKY_FLAGS_EN
        ,
        .flag_clr   (flag_clr),
        .sticky_ovf (sticky_ovf),
        .sticky_dz  (sticky_dz)
`endif
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic signed [W-1:0] sa, sb_;
        sa = a;
        sb_ = b;
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        e.lat = W + 3;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.ovf = 1'b1; e.lat = 1;
        end else if (sgn) begin
            e.q = sa / sb_;
            e.r = sa % sb_;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Drive a request and return just after its accept edge.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        sb.push_back(model(sgn, a, b));
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        while (!bus.ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check("ready_at_issue", bus.ready, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int lat = 1;
        while (!bus.valid_out && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_valid"}, bus.valid_out, 1'b1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_quotient"}, bus.quotient, e.q);
            check({tag, "_remainder"}, bus.remainder, e.r);
            check({tag, "_overflow"}, bus.overflow, e.ovf);
            check({tag, "_div_by_zero"}, bus.div_by_zero, e.dz);
        end
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_consumed_valid"}, bus.valid_out, 1'b0);
        check({tag, "_consumed_ready"}, bus.ready, 1'b1);
        check({tag, "_consumed_flags"}, {bus.overflow, bus.div_by_zero}, 2'b00);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(sgn, a, b);
        wait_result(tag);
        consume(tag);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 1'b1);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_quotient", bus.quotient, '0);
        check("rst_remainder", bus.remainder, '0);
        check("rst_flags", {bus.overflow, bus.div_by_zero}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Exception fast path
        run_op("s_min_by_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("u_100_by_0", 1'b0, 32'd100, 32'd0);
        run_op("s_m5_by_0", 1'b1, 32'hFFFF_FFFB, 32'd0);

        // Normal path and unsigned non-overflow corners
        run_op("u_max_by_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("u_min_by_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s_min_by_2", 1'b1, 32'h8000_0000, 32'd2);
        run_op("s_7_by_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        run_op("u_small_by_big", 1'b0, 32'd5, 32'd9);

        // Backpressure: outputs hold and start is ignored while DONE
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_result("s_m7_by_2");
        for (int k = 0; k < 5; k++) begin
            bus.start    = 1'b1;
            bus.dividend = 32'd1234 + 32'(k);
            bus.divisor  = 32'd0;
            @(posedge clk); #1;
            check("stall_valid", bus.valid_out, 1'b1);
            check("stall_ready", bus.ready, 1'b0);
            check("stall_quotient", bus.quotient, 32'hFFFF_FFFD);
            check("stall_remainder", bus.remainder, 32'hFFFF_FFFF);
            check("stall_flags", {bus.overflow, bus.div_by_zero}, 2'b00);
        end
        bus.start = 1'b0;
        consume("s_m7_by_2");

        // Reset during ITER abandons the operation
        issue(1'b0, 32'd123456789, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        check("mid_op_not_done", bus.valid_out, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete(sb.size() - 1);
        check("midrst_ready", bus.ready, 1'b1);
        check("midrst_valid", bus.valid_out, 1'b0);
        check("midrst_quotient", bus.quotient, '0);
        check("midrst_remainder", bus.remainder, '0);
        check("midrst_flags", {bus.overflow, bus.div_by_zero}, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("u_1000_by_7", 1'b0, 32'd1000, 32'd7);

        // Random operands in both modes
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? W'($urandom_range(1, 100)) : W'($urandom);
            if (i % 4 == 1) a = -a;
            if (b == '0) b = 32'd1;
            run_op("random", 1'(i % 2), a, b);
        end

`ifdef DIV_STICKY_FLAGS_EN
        check("sticky_idle_ovf", sticky_ovf, 1'b0);
        run_op("sticky_ovf_op", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("sticky_ovf_set", sticky_ovf, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("sticky_ovf_hold", sticky_ovf, 1'b1);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        check("sticky_ovf_clr", sticky_ovf, 1'b0);
        issue(1'b0, 32'd9, 32'd0);
        wait_result("sticky_dz_op");
        flag_clr      = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        flag_clr      = 1'b0;
        bus.out_ready = 1'b0;
        check("sticky_dz_set_wins", sticky_dz, 1'b1);
        check("sticky_ovf_stays_clr", sticky_ovf, 1'b0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
